// File: rtl/led_scan_n_if.sv
// Bus bundle for led_scan_n: capture sources, capture strobes, decimal points and display drive.
interface led_scan_n_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] max;
    logic [4*NUM_DIGITS-1:0] min;
    logic                    up;
    logic                    down;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   LedW;
    logic [7:0]              tub;
    logic                    scan_tick;

    modport master (output max, min, up, down, dp, input LedW, tub, scan_tick);
    modport slave  (input max, min, up, down, dp, output LedW, tub, scan_tick);
endinterface

// File: rtl/led_scan_n.sv
// Multiplexed seven-segment hex display driver: captures a value from max/min,
// scans NUM_DIGITS digits at DIV clocks per digit, drives active-low enables and segments.
// Optional macro LED_LZ_BLANK_EN blanks leading-zero digits (digit 0 always shown).
module led_scan_n #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned DIV        = 10000
) (
    input  logic        clk,
    input  logic        reset,
    led_scan_n_if.slave bus
);
    localparam int unsigned VAL_W = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [VAL_W-1:0]      shown, shown_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [IDX_W-1:0]      idx, idx_nxt;
    logic                  tick_nxt;
    logic [NUM_DIGITS-1:0] ledw_nxt;
    logic [7:0]            tub_nxt;
    logic [3:0]            nib;
    logic                  dp_bit;
    logic                  blank;
`ifdef LED_LZ_BLANK_EN
    logic [IDX_W-1:0]      msd;
`endif

    // Hex nibble to active-high segments a..g.
    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'b1111110;
            4'h1:    s = 7'b0110000;
            4'h2:    s = 7'b1101101;
            4'h3:    s = 7'b1111001;
            4'h4:    s = 7'b0110011;
            4'h5:    s = 7'b1011011;
            4'h6:    s = 7'b1011111;
            4'h7:    s = 7'b1110000;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1111011;
            4'hA:    s = 7'b1110111;
            4'hB:    s = 7'b0011111;
            4'hC:    s = 7'b1001110;
            4'hD:    s = 7'b0111101;
            4'hE:    s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        return s;
    endfunction

    // Capture, dwell divider and digit index advance.
    always_comb begin
        shown_nxt = shown;
        cnt_nxt   = cnt + 1'b1;
        idx_nxt   = idx;
        tick_nxt  = 1'b0;
        if (bus.up) begin
            shown_nxt = bus.max;
        end else if (bus.down) begin
            shown_nxt = bus.min;
        end
        if (cnt == CNT_LAST) begin
            cnt_nxt  = '0;
            tick_nxt = 1'b1;
            idx_nxt  = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
    end

    // Digit enable and segment pattern for the currently selected digit.
    always_comb begin
        nib    = 4'(shown >> {idx, 2'b00});
        dp_bit = 1'(bus.dp >> idx);
`ifdef LED_LZ_BLANK_EN
        msd = '0;
        for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
            if (4'(shown >> (4 * i)) != 4'h0) begin
                msd = IDX_W'(i);
            end
        end
        blank = (idx > msd);
`else
        blank = 1'b0;
`endif
        ledw_nxt = ~(NUM_DIGITS'(1) << idx);
        tub_nxt  = {(blank ? 7'h7F : ~seg_decode(nib)), ~dp_bit};
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            shown         <= '0;
            cnt           <= '0;
            idx           <= '0;
            bus.scan_tick <= 1'b0;
            bus.LedW      <= '1;
            bus.tub       <= 8'hFF;
        end else begin
            shown         <= shown_nxt;
            cnt           <= cnt_nxt;
            idx           <= idx_nxt;
            bus.scan_tick <= tick_nxt;
            bus.LedW      <= ledw_nxt;
            bus.tub       <= tub_nxt;
        end
    end
endmodule

// File: tb/tb_led_scan_n.sv
// Scoreboard bench for led_scan_n: three instances (4 digits/DIV=4, 1 digit/DIV=1,
// 8 digits/DIV=1) share stimulus; a reference model predicts each output per edge.
module tb_led_scan_n;
    logic        clk;
    logic        reset;
    logic [31:0] max_v;
    logic [31:0] min_v;
    logic        up;
    logic        down;
    logic [7:0]  dp_v;

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    led_scan_n_if #(.NUM_DIGITS(4)) b4 ();
    led_scan_n_if #(.NUM_DIGITS(1)) b1 ();
    led_scan_n_if #(.NUM_DIGITS(8)) b8 ();

    assign b4.max = max_v[15:0];
    assign b4.min = min_v[15:0];
    assign b4.up = up;
    assign b4.down = down;
    assign b4.dp = dp_v[3:0];
    assign b1.max = max_v[3:0];
    assign b1.min = min_v[3:0];
    assign b1.up = up;
    assign b1.down = down;
    assign b1.dp = dp_v[0:0];
    assign b8.max = max_v;
    assign b8.min = min_v;
    assign b8.up = up;
    assign b8.down = down;
    assign b8.dp = dp_v;

    led_scan_n #(.NUM_DIGITS(4), .DIV(4)) u4 (.clk(clk), .reset(reset), .bus(b4.slave));
    led_scan_n #(.NUM_DIGITS(1), .DIV(1)) u1 (.clk(clk), .reset(reset), .bus(b1.slave));
    led_scan_n #(.NUM_DIGITS(8), .DIV(1)) u8 (.clk(clk), .reset(reset), .bus(b8.slave));

    typedef struct packed {
        logic [7:0] ledw;
        logic [7:0] tub;
        logic       tick;
    } obs_t;

    typedef struct packed {
        obs_t d4;
        obs_t d1;
        obs_t d8;
    } exp_t;

    exp_t q[$];

    // Active-high a..g patterns for hex digits 0..F.
    logic [6:0] seg_tab [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    // Expected outputs after the e-th edge since reset (e=0 means the reset edge itself).
    function automatic obs_t model(int n, int div, int e, logic [31:0] shown, logic [7:0] dpv);
        obs_t       o;
        int         digit;
        logic [3:0] nb;
`ifdef LED_LZ_BLANK_EN
        int         msd;
`endif
        if (e == 0) begin
            o.ledw = 8'hFF;
            o.tub  = 8'hFF;
            o.tick = 1'b0;
            return o;
        end
        digit  = ((e - 1) / div) % n;
        o.ledw = ~(8'd1 << digit);
        nb     = 4'((shown >> (4 * digit)) & 32'hF);
        o.tub  = {~seg_tab[nb], ~dpv[3'(digit)]};
`ifdef LED_LZ_BLANK_EN
        msd = 0;
        for (int i = 0; i < n; i++) begin
            if (((shown >> (4 * i)) & 32'hF) != 32'h0) msd = i;
        end
        if (digit > msd) o.tub[7:1] = 7'h7F;
`endif
        o.tick = ((e % div) == 0);
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: predict each instance's registered outputs at every rising edge.
    initial begin
        int          e;
        logic [31:0] shown_m;
        exp_t        ex;
        e       = 0;
        shown_m = '0;
        forever begin
            @(posedge clk);
            if (!reset) e = 0;
            else e++;
            ex.d4 = model(4, 4, e, shown_m, dp_v);
            ex.d1 = model(1, 1, e, shown_m, dp_v);
            ex.d8 = model(8, 1, e, shown_m, dp_v);
            q.push_back(ex);
            if (!reset) shown_m = '0;
            else if (up) shown_m = max_v;
            else if (down) shown_m = min_v;
        end
    end

    // Monitor: compare presented outputs against the oldest prediction.
    initial begin
        exp_t ex;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                ex = q.pop_front();
                check("u4.LedW", 32'(b4.LedW), 32'(ex.d4.ledw & 8'h0F));
                check("u4.tub", 32'(b4.tub), 32'(ex.d4.tub));
                check("u4.scan_tick", 32'(b4.scan_tick), 32'(ex.d4.tick));
                check("u1.LedW", 32'(b1.LedW), 32'(ex.d1.ledw & 8'h01));
                check("u1.tub", 32'(b1.tub), 32'(ex.d1.tub));
                check("u1.scan_tick", 32'(b1.scan_tick), 32'(ex.d1.tick));
                check("u8.LedW", 32'(b8.LedW), 32'(ex.d8.ledw));
                check("u8.tub", 32'(b8.tub), 32'(ex.d8.tub));
                check("u8.scan_tick", 32'(b8.scan_tick), 32'(ex.d8.tick));
            end
        end
    end

    // Stimulus: directed scenarios followed by randomized traffic.
    initial begin
        logic found;
        reset = 1'b0;
        up    = 1'b0;
        down  = 1'b0;
        max_v = '0;
        min_v = '0;
        dp_v  = '0;
        cyc(3);
        check("reset LedW", 32'(b4.LedW), 32'h0000_000F);
        check("reset tub", 32'(b4.tub), 32'h0000_00FF);
        reset = 1'b1;
        cyc(1);
        check("release LedW", 32'(b4.LedW), 32'h0000_000E);
        check("release tub", 32'(b4.tub), 32'h0000_0003);
        cyc(20);

        max_v = 32'h8765_1234;
        min_v = 32'h4321_ABCD;
        up    = 1'b1;
        down  = 1'b1;
        cyc(1);
        up    = 1'b0;
        down  = 1'b0;
        cyc(18);
        down  = 1'b1;
        cyc(1);
        down  = 1'b0;
        cyc(18);

        max_v = 32'h0000_00F0;
        up    = 1'b1;
        cyc(1);
        up    = 1'b0;
        max_v = 32'hFFFF_1111;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc(1);
            if (b4.LedW == 4'b1101) found = 1'b1;
        end
        check("hold digit1 reached", 32'(found), 32'h1);
        if (found) check("hold digit1 tub", 32'(b4.tub), 32'h0000_0071);
        cyc(8);

        dp_v = 8'h80;
        cyc(12);
        dp_v = 8'h5A;
        cyc(12);
        dp_v = 8'h00;

        cyc(2);
        max_v = 32'hFFFF_FFFF;
        up    = 1'b1;
        reset = 1'b0;
        cyc(1);
        reset = 1'b1;
        up    = 1'b0;
        cyc(10);

        max_v = 32'h0000_0005;
        up    = 1'b1;
        cyc(1);
        up    = 1'b0;
        cyc(20);
        max_v = 32'h0000_0000;
        up    = 1'b1;
        cyc(1);
        up    = 1'b0;
        cyc(20);

        repeat (400) begin
            reset = ($urandom_range(0, 63) != 0);
            up    = ($urandom_range(0, 7) == 0);
            down  = ($urandom_range(0, 7) == 0);
            max_v = $urandom();
            min_v = $urandom();
            dp_v  = 8'($urandom());
            cyc(1);
        end
        reset = 1'b1;
        up    = 1'b0;
        down  = 1'b0;
        cyc(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/led_scan_n.md
LED_SCAN_N -- requirements
Module: led_scan_n

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits; legal range 1..8.
REQ-002 SHALL have parameter DIV, default 10000, clk cycles per digit dwell; legal range 1..2^26-1.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port max  input  4*NUM_DIGITS  first source value, one hex nibble per digit, digit 0 = bits [3:0].
REQ-006 SHALL have port min  input  4*NUM_DIGITS  second source value, same packing.
REQ-007 SHALL have port up  input  1  capture max this cycle.
REQ-008 SHALL have port down  input  1  capture min this cycle.
REQ-009 SHALL have port dp  input  NUM_DIGITS  decimal-point request per digit, 1 = lit, sampled live (not captured).
REQ-010 SHALL have port LedW  output  NUM_DIGITS  digit enables, active-low, one-cold.
REQ-011 SHALL have port tub  output  8  segments, active-low, bit7..bit1 = a..g, bit0 = dp.
REQ-012 SHALL have port scan_tick  output  1  one-cycle pulse at each digit advance.

Function
REQ-013 SHALL hold captured value reg `shown` (4*NUM_DIGITS bits); up=1 loads max, else down=1 loads min, else hold; up has priority when both high.
REQ-014 SHALL keep a divider counter 0..DIV-1; when it equals DIV-1 it wraps to 0 and scan_tick pulses high that same cycle (registered, so visible the following cycle).
REQ-015 SHALL keep digit index idx 0..NUM_DIGITS-1; on each divider wrap idx increments, wrapping NUM_DIGITS-1 -> 0; NUM_DIGITS=1 keeps idx at 0.
REQ-016 SHALL register LedW and tub every cycle from current idx, shown and dp: LedW = all ones except bit idx = 0; 1-cycle latency.
REQ-017 SHALL decode nibbles (active-high a..g before inversion): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
REQ-018 SHALL set tub[0] = ~dp[idx].
REQ-019 SHALL make a capture on cycle N visible on tub no later than cycle N+2 when idx already selects the changed digit; no tearing (all nibbles of one capture change together).
REQ-020 SHALL ignore unused upper bits: none exist; width strictly 4*NUM_DIGITS.

Reset
REQ-021 SHALL, on clk edge with reset=0: shown=0, divider=0, idx=0, scan_tick=0, LedW=all ones, tub=8'hFF.
REQ-022 SHALL give reset priority over up/down on the same edge; reset mid-dwell restarts dwell from 0.
REQ-023 SHALL after reset release drive digit 0 showing "0" (tub=8'h03 with dp=0) on the first edge.

Configuration
REQ-024 SHALL support macro LED_LZ_BLANK_EN: when defined, digits above the most significant nonzero nibble of shown drive tub=8'hFF except dp bit; digit 0 never blanked; LedW scanning unchanged.
REQ-025 SHALL, without LED_LZ_BLANK_EN, display every digit including leading zeros.

Verification
REQ-026 SHALL test reset: DIV=4, hold reset=0 3 cycles -> LedW=4'b1111, tub=8'hFF; release -> LedW=4'b1110, tub=8'h03.
REQ-027 SHALL test scan: DIV=4, NUM_DIGITS=4 -> LedW sequence 1110,1101,1011,0111,1110 each held 4 cycles, scan_tick every 4th cycle.
REQ-028 SHALL test priority: max=16'h1234, min=16'hABCD, up=down=1 one cycle -> digits read 4,3,2,1; then down only -> D,C,b,A.
REQ-029 SHALL test hold: capture 16'h00F0, then max changes with up=down=0 -> digit1 stays tub=8'h71 (F).
REQ-030 SHALL test blanking: LED_LZ_BLANK_EN, shown=16'h0005 -> digits 3,2,1 tub=8'hFF, digit0 tub=8'h49; shown=0 -> digit0 shows "0".
REQ-031 SHALL test parametrisation: NUM_DIGITS=1 and 8, DIV=1 -> idx advances every cycle, wraps correctly, dp[7]=1 clears tub[0] only on digit 7.
